encoder_sched: RTL

Sequencing controller for the dual priority-encoder cluster datapath, clocked at 160 MHz. It generates the 8-phase two-BX schedule and issues alternating latch strobes to encoder 0 (even BX) and encoder 1 (odd BX). It tracks each encoder's busy/output state via a done handshake and drives the output mux select and valid. It also detects missed latches, resync misalignment and encoder timeouts.

---
 rtl/encoder_sched_if.sv | 28 ++
 rtl/encoder_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/encoder_sched_if.sv
// encoder_sched_if: control/status bundle between the encoder cluster
// sequencer and its environment.
//   enable, resync, enc_done[1:0]  -> sequencer inputs
//   latch[1:0], mux_sel, out_valid, phase[2:0],
//   miss_cnt[7:0], sync_err, timeout_err -> sequencer outputs
// slave modport is the sequencer side; master is the driving environment.
interface encoder_sched_if;
    logic       enable;
    logic       resync;
    logic [1:0] enc_done;
    logic [1:0] latch;
    logic       mux_sel;
    logic       out_valid;
    logic [2:0] phase;
    logic [7:0] miss_cnt;
    logic       sync_err;
    logic       timeout_err;

    modport master (
        output enable, resync, enc_done,
        input  latch, mux_sel, out_valid, phase, miss_cnt, sync_err, timeout_err
    );

    modport slave (
        input  enable, resync, enc_done,
        output latch, mux_sel, out_valid, phase, miss_cnt, sync_err, timeout_err
    );
endinterface

// File: rtl/encoder_sched.sv
// encoder_sched: 8-phase two-BX sequencer for the dual priority-encoder
// cluster. Encoder 0 is latched from the phase-0 slot, encoder 1 from the
// phase-4 slot; each encoder runs IDLE -> ENCODE -> OUTPUT -> IDLE and the
// output mux follows whichever encoder entered OUTPUT first.
// Ports:
//   clock4x       160 MHz clock
//   global_reset  synchronous active-high reset
//   sched         encoder_sched_if.slave (enable/resync/enc_done in;
//                 latch/mux_sel/out_valid/phase/miss_cnt/sync_err/
//                 timeout_err out, all registered)
// Build option: ENCODER_SCHED_STATS_EN enables miss_cnt, sync_err and
// timeout_err; without it those outputs are tied to zero.
module encoder_sched #(
    parameter int unsigned OUT_HOLD = 4,
    parameter int unsigned TIMEOUT  = 12
) (
    input  logic           clock4x,
    input  logic           global_reset,
    encoder_sched_if.slave sched
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PH_W   = 3;
    localparam int unsigned MISS_W = 8;
    localparam int unsigned N_ENC  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_OUTPUT = 2'd2
    } enc_state_e;

    enc_state_e       state_q [N_ENC];
    enc_state_e       state_d [N_ENC];
    logic [CNT_W-1:0] cnt_q   [N_ENC];
    logic [CNT_W-1:0] cnt_d   [N_ENC];
    logic [PH_W-1:0]  phase_q, phase_d, slot_phase;
    logic [N_ENC-1:0] latch_q, latch_d;
    logic [N_ENC-1:0] slot_hit, in_out_d, enter_out;
    logic             mux_sel_q, mux_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             miss_inc, timeout_hit;

    // Next-state: phase, per-encoder FSMs, output mux
    always_comb begin
        phase_d     = sched.resync ? PH_W'(1) : phase_q + PH_W'(1);
        // The resync cycle itself acts as phase 0 for slot decisions
        slot_phase  = sched.resync ? PH_W'(0) : phase_q;
        slot_hit[0] = sched.enable && (slot_phase == PH_W'(0));
        slot_hit[1] = sched.enable && (slot_phase == PH_W'(4));
        latch_d     = '0;
        miss_inc    = 1'b0;
        timeout_hit = 1'b0;

        for (int i = 0; i < int'(N_ENC); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (slot_hit[i]) begin
                        state_d[i] = ST_ENCODE;
                        cnt_d[i]   = '0;
                        latch_d[i] = 1'b1;
                    end
                end
                ST_ENCODE: begin
                    if (slot_hit[i]) miss_inc = 1'b1;
                    if (sched.enc_done[i]) begin
                        state_d[i] = ST_OUTPUT;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                        state_d[i]  = ST_IDLE;
                        timeout_hit = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (slot_hit[i]) miss_inc = 1'b1;
                    if (cnt_q[i] == CNT_W'(OUT_HOLD - 1)) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end

        for (int i = 0; i < int'(N_ENC); i++) begin
            in_out_d[i]  = (state_d[i] == ST_OUTPUT);
            enter_out[i] = in_out_d[i] && (state_q[i] != ST_OUTPUT);
        end
        out_valid_d = |in_out_d;

        // First encoder into OUTPUT owns the mux; joint entry goes to encoder 0
        mux_sel_d = mux_sel_q;
        case (in_out_d)
            2'b01:   mux_sel_d = 1'b1;
            2'b10:   mux_sel_d = 1'b0;
            2'b11:   if (&enter_out) mux_sel_d = 1'b1;
            default: mux_sel_d = mux_sel_q;
        endcase
    end

    // Scheduling state registers
    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            phase_q     <= '0;
            latch_q     <= '0;
            mux_sel_q   <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < int'(N_ENC); i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            latch_q     <= latch_d;
            mux_sel_q   <= mux_sel_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < int'(N_ENC); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sched.phase     = phase_q;
    assign sched.latch     = latch_q;
    assign sched.mux_sel   = mux_sel_q;
    assign sched.out_valid = out_valid_q;

`ifdef ENCODER_SCHED_STATS_EN
    logic [MISS_W-1:0] miss_q;
    logic              sync_err_q, timeout_err_q;

    // Saturating miss counter and sticky error flags
    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            miss_q        <= '0;
            sync_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (miss_inc && (miss_q != '1)) miss_q <= miss_q + MISS_W'(1);
            if (sched.resync && (phase_q != '0)) sync_err_q <= 1'b1;
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end

    assign sched.miss_cnt    = miss_q;
    assign sched.sync_err    = sync_err_q;
    assign sched.timeout_err = timeout_err_q;
`else
    logic unused_stats;
    assign unused_stats      = ^{miss_inc, timeout_hit};
    assign sched.miss_cnt    = '0;
    assign sched.sync_err    = 1'b0;
    assign sched.timeout_err = 1'b0;
`endif
endmodule
